serial_demux_router: RTL and testbench
======================================

// Module: serial_demux_router
// PURPOSE
//  Parametrised serial frame receiver and demultiplexer: 1-bit stream -> 2**PORT_W channels.
//  Frame on serIn (MSB first): start bit (0), PORT_W-bit port id, CNT_W-bit length N,
//  N payload bits, stop bit (1).
//  Payload bits are steered to the addressed channel with a per-channel valid.
//  Adds over the fixed-width generation: zero-length frames, stop-bit check, error flag and frame counter.
// PARAMETERS
//  PORT_W   2   port id width; channel count NCH = 2**PORT_W (localparam)
//  CNT_W    4   length field width; N in 0 .. 2**CNT_W-1
//  FCNT_W   8   width of good-frame counter
// PORTS
//  clk          in   1        system clock, all state on posedge
//  rst          in   1        synchronous reset, active-low
//  clkEn        in   1        bit strobe; state/registers advance only on edges with clkEn=1
//  serIn        in   1        serial input, idle high
//  serOut       out  NCH      payload bit per channel (0 on non-addressed channels)
//  serOutValid  out  NCH      payload valid per channel, one-hot or zero
//  port         out  PORT_W   latched port id of current/last frame
//  len          out  CNT_W    latched length of current/last frame
//  busy         out  1        frame in progress (state != IDLE)
//  done         out  1        receiver idle (state == IDLE); done = ~busy
//  frameErr     out  1        one-cycle pulse: stop bit sampled 0
//  frameCnt     out  FCNT_W   count of frames ended with a good stop bit
// BEHAVIOUR
//  Reset: on a posedge with rst=0, regardless of clkEn:
//   state=IDLE, port=0, len=0, bit counters=0, frameErr=0, frameCnt=0.
//   Hence serOutValid=0, serOut=0, done=1, busy=0.
//  Reset mid-frame aborts the frame; no error, no count.
//  Sampling: serIn is sampled only on edges with clkEn=1. clkEn=0 holds every register.
//  FSM (Moore, states IDLE/PORT/LEN/DATA/STOP):
//   IDLE: serIn=0 -> PORT, bitCnt<=0; serIn=1 -> stay.
//   PORT: port<={port[PORT_W-2:0],serIn}; after PORT_W samples -> LEN.
//    PORT_W=1 is a plain load.
//   LEN:  len<={len[CNT_W-2:0],serIn}; after CNT_W samples:
//    assembled value==0 -> STOP;
//    otherwise -> DATA, dataCnt<=value.
//   DATA: serOutValid[port]=clkEn; serOut[port]=serIn (combinational pass-through).
//    Consumers capture on the same edge. Each enabled edge: dataCnt--.
//    dataCnt==1 on an enabled edge -> STOP.
//    Exactly N valid cycles are produced.
//   STOP: serIn=1 -> IDLE, frameCnt++ (wraps 2**FCNT_W-1 -> 0).
//    serIn=0 -> IDLE, frameErr=1 for exactly one clk cycle (registered); frameCnt unchanged.
//  Latency: first payload bit valid in the cycle after PORT_W+CNT_W+1 enabled edges from start.
//   Frame occupies 1+PORT_W+CNT_W+N+1 enabled edges.
//  Back-to-back: a 0 sampled in the first IDLE edge after STOP starts the next frame. No gap is required.
//  port/len hold their values after the frame until the next frame overwrites them.
//  Outside DATA: serOutValid=0 and serOut=0 on all channels.
//  No state other than IDLE ever lasts while clkEn=1 without progressing.
// TESTING (PORT_W=2, CNT_W=4, clkEn=1 unless stated)
//  1 serIn 0,10,0011,101,1 -> serOutValid[2] high 3 cycles, serOut[2]=1,0,1.
//    Other channels 0; frameCnt=1; done=1 after stop.
//  2 zero-length 0,01,0000,1 -> no valid; frameCnt+1; IDLE 8 edges after start.
//  3 bad stop: 0,11,0001,1,0 -> serOutValid[3] one cycle; frameErr 1-cycle pulse; frameCnt unchanged.
//  4 clkEn alternating 1/0 through frame 1 -> valid only on clkEn=1 cycles.
//    Same data; state held on clkEn=0.
//  5 rst=0 during 2nd DATA bit -> next cycle: done=1, valids 0, frameCnt=0.
//    A new frame is received normally.
//  6 N=15 frame then immediate start bit -> 15 valids on the addressed channel.
//    Second frame decoded; frameCnt=2. Also wrap check 255->0 with FCNT_W=8.

Source files
------------

// File: rtl/serial_demux_router.sv
// Serial frame receiver: start bit, port id, length, N payload bits, stop bit.
// Payload bits are passed combinationally to the addressed channel while in DATA.
module serial_demux_router #(
  parameter int PORT_W = 2,
  parameter int CNT_W  = 4,
  parameter int FCNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clkEn,
  input  logic                   serIn,
  output logic [2**PORT_W-1:0]   serOut,
  output logic [2**PORT_W-1:0]   serOutValid,
  output logic [PORT_W-1:0]      port,
  output logic [CNT_W-1:0]       len,
  output logic                   busy,
  output logic                   done,
  output logic                   frameErr,
  output logic [FCNT_W-1:0]      frameCnt
);
  localparam int NCH    = 2**PORT_W;
  localparam int BCNT_W = $clog2((PORT_W > CNT_W) ? PORT_W : CNT_W) + 1;

  typedef enum logic [2:0] {S_IDLE, S_PORT, S_LEN, S_DATA, S_STOP} state_t;

  state_t              state_q, state_d;
  logic [PORT_W-1:0]   port_q, port_d, port_shift;
  logic [CNT_W-1:0]    len_q, len_d, len_shift;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    data_cnt_q, data_cnt_d;
  logic                frame_err_q, frame_err_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  // Width-1 fields degenerate to a plain load of the sampled bit.
  if (PORT_W == 1) begin : g_port_load
    assign port_shift = serIn;
  end else begin : g_port_shift
    assign port_shift = {port_q[PORT_W-2:0], serIn};
  end

  if (CNT_W == 1) begin : g_len_load
    assign len_shift = serIn;
  end else begin : g_len_shift
    assign len_shift = {len_q[CNT_W-2:0], serIn};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      port_q      <= '0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      data_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      len_q       <= len_d;
      bit_cnt_q   <= bit_cnt_d;
      data_cnt_q  <= data_cnt_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    len_d       = len_q;
    bit_cnt_d   = bit_cnt_q;
    data_cnt_d  = data_cnt_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (clkEn) begin
      case (state_q)
        S_IDLE: begin
          if (!serIn) begin
            state_d   = S_PORT;
            bit_cnt_d = '0;
          end
        end
        S_PORT: begin
          port_d = port_shift;
          if (bit_cnt_q == BCNT_W'(PORT_W - 1)) begin
            state_d   = S_LEN;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end
        S_LEN: begin
          len_d = len_shift;
          if (bit_cnt_q == BCNT_W'(CNT_W - 1)) begin
            bit_cnt_d = '0;
            if (len_shift == '0) begin
              state_d = S_STOP;
            end else begin
              state_d    = S_DATA;
              data_cnt_d = len_shift;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end
        S_DATA: begin
          data_cnt_d = data_cnt_q - CNT_W'(1);
          if (data_cnt_q == CNT_W'(1)) state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (serIn) frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          else       frame_err_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    serOutValid = '0;
    serOut      = '0;
    if (state_q == S_DATA) begin
      serOutValid[port_q] = clkEn;
      serOut[port_q]      = serIn;
    end
    busy = (state_q != S_IDLE);
    done = ~busy;
  end

  assign port     = port_q;
  assign len      = len_q;
  assign frameErr = frame_err_q;
  assign frameCnt = frame_cnt_q;

  // Keeps NCH referenced for readers; it equals the output vector width.
  logic unused_ok;
  assign unused_ok = (NCH == 0);
endmodule

// File: tb/tb_serial_demux_router.sv
// Directed-frame bench: a frame-level model derives per-cycle expectations from bit position.
module tb_serial_demux_router;
  localparam int PW  = 2;
  localparam int CW  = 4;
  localparam int FW  = 8;
  localparam int NCH = 2**PW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clkEn = 1'b0;
  logic serIn = 1'b1;
  logic [NCH-1:0] serOut, serOutValid;
  logic [PW-1:0]  port;
  logic [CW-1:0]  len;
  logic           busy, done, frameErr;
  logic [FW-1:0]  frameCnt;

  serial_demux_router #(.PORT_W(PW), .CNT_W(CW), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .serIn(serIn),
    .serOut(serOut), .serOutValid(serOutValid), .port(port), .len(len),
    .busy(busy), .done(done), .frameErr(frameErr), .frameCnt(frameCnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  logic [FW-1:0]  m_cnt = '0;
  logic           err_pend = 1'b0;
  logic [PW-1:0]  m_port = '0;
  logic [CW-1:0]  m_len = '0;
  logic           chk_pl = 1'b1;

  // expectations for the current cycle
  logic           chk_en = 1'b0;
  logic           exp_busy, exp_err, exp_chk_pl;
  logic [NCH-1:0] exp_valid, exp_out;
  logic [FW-1:0]  exp_cnt;
  logic [PW-1:0]  exp_port;
  logic [CW-1:0]  exp_len;

  int vcount [NCH];
  int err_seen = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("done", done, !exp_busy);
      check("serOutValid", serOutValid, exp_valid);
      check("serOut", serOut, exp_out);
      check("frameErr", frameErr, exp_err);
      check("frameCnt", frameCnt, exp_cnt);
      if (exp_chk_pl) begin
        check("port", port, exp_port);
        check("len", len, exp_len);
      end
      for (int c = 0; c < NCH; c++) vcount[c] += int'(serOutValid[c]);
      if (frameErr) err_seen++;
    end
  end

  task automatic drive(input logic s, input logic en, input logic r, input logic busy_e,
                       input logic dv, input int ch, input logic is_stop);
    serIn = s; clkEn = en; rst = r;
    exp_busy = busy_e;
    exp_valid = '0;
    exp_out = '0;
    if (dv && en) exp_valid[ch] = 1'b1;
    if (dv && s)  exp_out[ch] = 1'b1;
    exp_err = err_pend; exp_cnt = m_cnt;
    exp_port = m_port; exp_len = m_len; exp_chk_pl = chk_pl;
    chk_en = 1'b1;
    @(posedge clk); #1;
    if (!r) begin
      m_cnt = '0; err_pend = 1'b0; m_port = '0; m_len = '0; chk_pl = 1'b1;
    end else begin
      err_pend = is_stop && en && !s;
      if (is_stop && en && s) m_cnt = m_cnt + 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Bit k of a frame: 0 start, 1..PW port, then CW length, n payload, stop.
  task automatic send_frame(input int p, input int n, input logic [15:0] pl, input logic sb,
                            input bit alt, input int abort_at);
    int total;
    total = 1 + PW + CW + n + 1;
    for (int k = 0; k < total; k++) begin
      logic b, dv, st;
      if (k == 0)               b = 1'b0;
      else if (k <= PW)         b = p[PW-k];
      else if (k <= PW + CW)    b = n[CW-(k-PW)];
      else if (k < total - 1)   b = pl[n-1-(k-1-PW-CW)];
      else                      b = sb;
      dv = (k > PW + CW) && (k < total - 1);
      st = (k == total - 1);
      if (k >= 1 && k <= PW + CW) chk_pl = 1'b0;
      if (k == PW + CW + 1) begin
        m_port = PW'(p); m_len = CW'(n); chk_pl = 1'b1;
      end
      if (alt) drive(~b, 1'b0, 1'b1, k > 0, dv, p, st);
      if (k == abort_at) begin
        drive(b, 1'b1, 1'b0, k > 0, dv, p, st);
        return;
      end
      drive(b, 1'b1, 1'b1, k > 0, dv, p, st);
    end
  endtask

  task automatic clear_vcount();
    for (int c = 0; c < NCH; c++) vcount[c] = 0;
  endtask

  initial begin
    clear_vcount();
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", done, 1);
    check("reset_busy", busy, 0);
    check("reset_cnt", frameCnt, 0);
    check("reset_port", port, 0);
    check("reset_len", len, 0);
    check("reset_valid", serOutValid, 0);
    idle(3);

    // 1: port 2, len 3, payload 101
    send_frame(2, 3, 16'b101, 1'b1, 0, -1);
    idle(2);
    check("t1_cnt", frameCnt, 1);
    check("t1_valid_ch2", vcount[2], 3);
    check("t1_valid_other", vcount[0] + vcount[1] + vcount[3], 0);
    check("t1_port", port, 2);
    check("t1_len", len, 3);

    // 2: zero-length frame to port 1
    clear_vcount();
    send_frame(1, 0, 16'h0, 1'b1, 0, -1);
    idle(2);
    check("t2_cnt", frameCnt, 2);
    check("t2_no_valid", vcount[0] + vcount[1] + vcount[2] + vcount[3], 0);

    // 3: bad stop bit
    clear_vcount(); err_seen = 0;
    send_frame(3, 1, 16'b1, 1'b0, 0, -1);
    idle(3);
    check("t3_cnt", frameCnt, 2);
    check("t3_err_pulses", err_seen, 1);
    check("t3_valid_ch3", vcount[3], 1);

    // 4: clkEn alternating through frame 1
    clear_vcount();
    send_frame(2, 3, 16'b101, 1'b1, 1, -1);
    idle(2);
    check("t4_cnt", frameCnt, 3);
    check("t4_valid_ch2", vcount[2], 3);

    // 5: reset during the second payload bit, then a normal frame
    send_frame(1, 4, 16'b1100, 1'b1, 0, 1 + PW + CW + 1);
    check("t5_done", done, 1);
    check("t5_cnt", frameCnt, 0);
    check("t5_valid", serOutValid, 0);
    idle(1);
    send_frame(0, 2, 16'b10, 1'b1, 0, -1);
    idle(1);
    check("t5_cnt_after", frameCnt, 1);

    // 6: N=15 then immediate next frame, from a fresh reset
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(1);
    clear_vcount();
    send_frame(3, 15, 16'h5A3C, 1'b1, 0, -1);
    send_frame(2, 2, 16'b11, 1'b1, 0, -1);
    idle(2);
    check("t6_valid_ch3", vcount[3], 15);
    check("t6_valid_ch2", vcount[2], 2);
    check("t6_cnt", frameCnt, 2);
    check("t6_port", port, 2);

    // counter wrap: 253 more frames reach 255, three more wrap to 2
    for (int f = 0; f < 253; f++) send_frame(0, 0, 16'h0, 1'b1, 0, -1);
    idle(1);
    check("wrap_255", frameCnt, 255);
    send_frame(1, 0, 16'h0, 1'b1, 0, -1);
    idle(1);
    check("wrap_0", frameCnt, 0);
    for (int f = 0; f < 2; f++) send_frame(0, 0, 16'h0, 1'b1, 0, -1);
    idle(1);
    check("wrap_2", frameCnt, 2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
